// File: rtl/timer_irq_ctrl.sv
// Timer END-flag edge to latched, maskable CPU interrupt with W1C acknowledge and status word.
// Optional missed-event counter enabled by defining TIMER_IRQ_MISS_CNT_EN.
module timer_irq_ctrl #(
  parameter int END_BIT = 4,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] timer_in,
  input  logic        WE,
  input  logic [31:0] Entrada,
  output logic        irq,
  output logic        event_pulse,
  output logic [31:0] Salida
);

  typedef enum logic {IDLE, PEND} state_e;

  state_e     state_q, state_d;
  logic       end_prev_q;
  logic       en_q, en_d;
  logic       irq_q, pulse_q;
  logic       flag, edge_det, ack, hit;
  logic [7:0] miss8;

  assign flag     = timer_in[END_BIT];
  assign edge_det = flag & ~end_prev_q;
  assign ack      = WE & Entrada[1];
  assign hit      = edge_det & en_q;
  assign en_d     = WE ? Entrada[0] : en_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = PEND;
      PEND:    if (ack && !hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      end_prev_q <= 1'b0;
      en_q       <= 1'b0;
      irq_q      <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      end_prev_q <= flag;
      en_q       <= en_d;
      irq_q      <= (state_d == PEND) & en_d;
      pulse_q    <= edge_det;
    end
  end

`ifdef TIMER_IRQ_MISS_CNT_EN
  logic [CNT_W-1:0] miss_q, miss_d;

  // Clear has priority over a coincident miss.
  always_comb begin
    miss_d = miss_q;
    if (hit && state_q == PEND && !ack && miss_q != '1)
      miss_d = miss_q + CNT_W'(1);
    if (WE && Entrada[2])
      miss_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) miss_q <= '0;
    else      miss_q <= miss_d;
  end

  assign miss8 = 8'(miss_q);
`else
  assign miss8 = 8'h00;
`endif

  logic unused_bits;
  assign unused_bits = ^{timer_in, Entrada};

  assign irq         = irq_q;
  assign event_pulse = pulse_q;
  assign Salida      = {16'b0, miss8, 6'b0, state_q == PEND, en_q};

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl; expectations adapt to TIMER_IRQ_MISS_CNT_EN.
module tb_timer_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] timer_in;
  logic        WE;
  logic [31:0] Entrada;
  logic        irq, event_pulse;
  logic [31:0] Salida;

  int checks = 0;
  int fails  = 0;

`ifdef TIMER_IRQ_MISS_CNT_EN
  localparam logic [31:0] M3   = 32'h0000_0300;
  localparam logic [31:0] MSAT = 32'h0000_FF00;
`else
  localparam logic [31:0] M3   = 32'h0;
  localparam logic [31:0] MSAT = 32'h0;
`endif

  timer_irq_ctrl #(.END_BIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .timer_in(timer_in), .WE(WE), .Entrada(Entrada),
    .irq(irq), .event_pulse(event_pulse), .Salida(Salida)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and samples sit 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    WE = 1'b1; Entrada = d;
    tick();
    WE = 1'b0; Entrada = 32'h0;
  endtask

  task automatic pulse_flag();
    timer_in = 32'h0;  tick();
    timer_in = 32'h10; tick();
  endtask

  initial begin
    rst = 1'b0; timer_in = 32'h10; WE = 1'b0; Entrada = 32'h0;
    tick(); tick();
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_salida", Salida, 32'h0);
    chk("rst_pulse", {31'b0, event_pulse}, 32'h0);

    // Flag already high at release: edge seen but ignored (en=0)
    rst = 1'b1;
    tick();
    chk("post_rst_pulse", {31'b0, event_pulse}, 32'h1);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);
    chk("post_rst_salida", Salida, 32'h0);

    timer_in = 32'h0; tick();
    wr(32'h1);
    chk("en_salida", Salida, 32'h1);
    chk("en_irq", {31'b0, irq}, 32'h0);

    timer_in = 32'h10; tick();
    chk("ev_pulse", {31'b0, event_pulse}, 32'h1);
    chk("ev_irq", {31'b0, irq}, 32'h1);
    chk("ev_salida", Salida, 32'h3);
    tick();
    chk("ev_pulse_1cyc", {31'b0, event_pulse}, 32'h0);
    chk("ev_irq_hold", {31'b0, irq}, 32'h1);

    wr(32'h3);
    chk("ack_irq", {31'b0, irq}, 32'h0);
    chk("ack_salida", Salida, 32'h1);

    pulse_flag();
    chk("repend_irq", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 3; i++) pulse_flag();
    chk("miss3_salida", Salida, M3 | 32'h3);
    chk("miss3_irq", {31'b0, irq}, 32'h1);

    // Ack coincident with new enabled edge: new event wins
    timer_in = 32'h0; tick();
    timer_in = 32'h10; WE = 1'b1; Entrada = 32'h3; tick();
    WE = 1'b0; Entrada = 32'h0;
    chk("ack_edge_salida", Salida, M3 | 32'h3);
    chk("ack_edge_irq", {31'b0, irq}, 32'h1);

    wr(32'h5);
    chk("clr_salida", Salida, 32'h3);
    // Clear coincident with a miss: clear wins
    timer_in = 32'h0; tick();
    timer_in = 32'h10; WE = 1'b1; Entrada = 32'h5; tick();
    WE = 1'b0; Entrada = 32'h0;
    chk("clr_miss_salida", Salida, 32'h3);

    wr(32'h0);
    chk("dis_irq", {31'b0, irq}, 32'h0);
    chk("dis_salida", Salida, 32'h2);
    pulse_flag();
    chk("dis_edge_pulse", {31'b0, event_pulse}, 32'h1);
    chk("dis_edge_salida", Salida, 32'h2);
    wr(32'h1);
    chk("reen_irq", {31'b0, irq}, 32'h1);
    chk("reen_salida", Salida, 32'h3);

    for (int i = 0; i < 300; i++) pulse_flag();
    chk("sat_salida", Salida, MSAT | 32'h3);
    chk("sat_irq", {31'b0, irq}, 32'h1);

    wr(32'h3);
    chk("ack2_salida", Salida, MSAT | 32'h1);
    wr(32'h3);
    chk("ack_idle_salida", Salida, MSAT | 32'h1);
    chk("ack_idle_irq", {31'b0, irq}, 32'h0);

    // Flag held high: no further events
    tick(); tick(); tick();
    chk("held_pulse", {31'b0, event_pulse}, 32'h0);
    chk("held_salida", Salida, MSAT | 32'h1);

    pulse_flag();
    chk("pre_arst_irq", {31'b0, irq}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_salida", Salida, 32'h0);
    chk("arst_pulse", {31'b0, event_pulse}, 32'h0);
    tick();
    rst = 1'b1;
    timer_in = 32'h0; tick();
    chk("after_arst_salida", Salida, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
